// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one registered ALU between two requesters.
// One operation in flight: grant in IDLE, wait out the ALU latency in EXEC, hold the result in RESP.
module alu_arbiter #(
    parameter int unsigned N       = 8,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_s,
    input  logic [N-1:0] alu_f,
    input  logic         alu_g,
    input  logic         alu_e,
    input  logic         alu_l,
    input  logic         alu_zero,
    input  logic         alu_carry,
    input  logic         alu_ovf,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_f,
    output logic [5:0]   rsp_flags,
    output logic         busy
);

    localparam int unsigned CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t        state_q, state_d;
    logic          last_grant_q;
    logic          id_q;
    logic [CW-1:0] cnt_q;
    logic          grant;
    logic          handshake;

    // Contested cycles go to whichever requester was not granted last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req0_valid || req1_valid) state_d = StExec;
            StExec: if (cnt_q == '0) state_d = StResp;
            StResp: if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == StIdle) begin
            req0_ready = req0_valid && !grant;
            req1_ready = req1_valid && grant;
        end
        busy      = (state_q != StIdle);
        rsp_valid = (state_q == StResp);
    end

    assign handshake = req0_ready || req1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_s        <= 4'b0000;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            rsp_id       <= 1'b0;
            rsp_f        <= '0;
            rsp_flags    <= '0;
        end else begin
            if (handshake) begin
                alu_a        <= grant ? req1_a : req0_a;
                alu_b        <= grant ? req1_b : req0_b;
                alu_s        <= grant ? req1_op : req0_op;
                id_q         <= grant;
                last_grant_q <= grant;
                cnt_q        <= CW'(ALU_LAT);
            end
            if (state_q == StExec) begin
                if (cnt_q == '0) begin
                    rsp_f     <= alu_f;
                    rsp_flags <= {alu_g, alu_e, alu_l, alu_zero, alu_carry, alu_ovf};
                    rsp_id    <= id_q;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one registered `ALU_TOP` instance between two requesters. It accepts an operation from either requester over a valid/ready handshake and drives the ALU operand and select inputs. It waits out the ALU latency, captures the result and flags, and returns them with the requester ID over a valid/ready response channel. Only one operation is in flight at a time. The block sits directly in front of `ALU_TOP`; the ALU's `clk`/`rst` are shared with this block.

## Interface
- `N`, 8, operand/result width (must match the ALU)
- `ALU_LAT`, 1, ALU clock-edge latency from operand/select change to registered result (≥1)

- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req0_valid` / `req1_valid`  in  1  requester 0/1 has an operation pending
- `req0_ready` / `req1_ready`  out  1  operation accepted this cycle (handshake on valid&ready at rising edge)
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  N  signed operands
- `req0_op` / `req1_op`  in  4  ALU select code, passed unmodified to `alu_s`
- `alu_a`, `alu_b`  out  N  registered ALU operands
- `alu_s`  out  4  registered ALU select
- `alu_f`  in  N  ALU result
- `alu_g`, `alu_e`, `alu_l`, `alu_zero`, `alu_carry`, `alu_ovf`  in  1 each  ALU flags
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer accepts response
- `rsp_id`  out  1  requester that issued the operation
- `rsp_f`  out  N  captured result
- `rsp_flags`  out  6  captured {G,E,L,Zero,carryOut,Overflow}
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state: IDLE.
- IDLE:
  - Grant `g` = requester 1 if only req1 valid.
  - Grant `g` = requester 0 if only req0 valid.
  - If both are valid, grant goes to the requester not granted last (`last_grant` register, reset to 1, so requester 0 wins first).
  - `reqg_ready` = 1 combinationally, only in IDLE, only for the granted requester with valid high. Never both readies high.
  - On handshake: `alu_a`/`alu_b`/`alu_s` <= granted operands/op; `id_q` <= g; `last_grant` <= g; `cnt` <= ALU_LAT; go to EXEC.
- EXEC:
  - Every cycle, `cnt` <= `cnt`-1.
  - When `cnt`==0 at an edge: `rsp_f` <= `alu_f`, `rsp_flags` <= flags, `rsp_id` <= `id_q`; go to RESP.
  - `alu_*` held stable throughout.
- RESP:
  - `rsp_valid`=1; `rsp_*` held stable until `rsp_valid`&`rsp_ready` at an edge, then go to IDLE.
  - No grants while in RESP. No bypass from RESP directly to a new grant.
- `last_grant` changes only on accepted handshakes; a requester dropping valid without a handshake does not affect fairness.
- Requesters must hold valid and payload until ready. The block does not check this.
- `alu_s` is opaque: no decoding, and no width change on operands or result.

## Timing
- Reset values: `req*_ready`=0, `alu_a`=0, `alu_b`=0, `alu_s`=4'b0000, `rsp_valid`=0, `rsp_id`=0, `rsp_f`=0, `rsp_flags`=0, `busy`=0, `cnt`=0, `last_grant`=1.
- Accept at edge E0 → `alu_*` valid after E0 → capture at edge E(ALU_LAT+1) → `rsp_valid` high from E(ALU_LAT+1) onward. With ALU_LAT=1: response visible 2 cycles after accept.
- Minimum issue interval: ALU_LAT+3 cycles (accept, ALU_LAT+1 EXEC cycles, 1 RESP cycle with `rsp_ready`=1).
- `rsp_ready` held low: RESP persists indefinitely, outputs frozen, both readies 0.
- Reset asserted mid-EXEC or mid-RESP: immediate return to IDLE with reset values. The in-flight operation is dropped and no response is produced.
- Simultaneous valids arriving in the same cycle as the `rsp` handshake: not sampled until the following IDLE cycle.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs immediately at reset values; `busy`=0.
- Single op: req0 A=5, B=3, op=4'b0000, ALU stub returns F=8 after 1 edge → `req0_ready` high in the first IDLE cycle, `alu_s`=0000, then `rsp_valid`, `rsp_id`=0, `rsp_f`=8, 2 cycles after accept.
- Fairness: both valids held high for 6 operations, `rsp_ready`=1 → grant order 0,1,0,1,0,1; each operand pair reaches `alu_a`/`alu_b` correctly.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_*` stable; `req0_ready`=`req1_ready`=0 throughout; release → IDLE next cycle.
- Flag/extreme passthrough: req1 A=-128, B=-128, op=4'b1100; stub F=8'h80, flags 6'b010111 → `rsp_f`=8'h80, `rsp_flags`=6'b010111, `rsp_id`=1.
- Reset mid-EXEC with ALU_LAT=3 → no `rsp_valid`; next simultaneous request is granted to requester 0.
